trace_feeder: RTL and testbench
===============================

Name: trace_feeder

Overview:
Upstream feeder for the trace reader stage. Holds a preloaded trace of packed entries in an internal memory and streams them in order. Each entry is {flag, priority, tree_id, data} or {flag, idle_cycle}. An entry is presented combinationally only while the consumer asserts its read strobe; at all other times the output is driven to zero, which the consumer requires. Supports single-pass or looped replay and abort.

Parameters:
TRACE_DATA_BITS, 25, width of one trace entry (flag MSB + payload)
DEPTH, 1024, trace memory entries
ADDR_BITS, $clog2(DEPTH), memory address width
LEN_BITS, $clog2(DEPTH)+1, trace length width (0..DEPTH)
CNT_BITS, 32, sent-entry counter width

Ports:
i_clk  in  1  clock
i_arst  in  1  asynchronous reset, active-high
i_load_en  in  1  write strobe for trace memory (honoured only in IDLE/DONE)
i_load_addr  in  ADDR_BITS  write address
i_load_data  in  TRACE_DATA_BITS  write data
i_trace_len  in  LEN_BITS  number of valid entries, sampled on start
i_loop  in  1  1 = wrap to entry 0 after last entry, sampled on start
i_start  in  1  start pulse
i_stop  in  1  abort pulse
i_read  in  1  consumer read strobe (consumer idle counter == 0)
o_trace_data  out  TRACE_DATA_BITS  entry to consumer; '0 unless delivering
o_busy  out  1  state is PRIME or RUN
o_done  out  1  state is DONE
o_sent_cnt  out  CNT_BITS  entries delivered since last start (saturating)

Behaviour:
- Reset (async, i_arst=1): state IDLE; rd_ptr=0; head_valid=0; o_trace_data=0; o_busy=0; o_done=0; o_sent_cnt=0. Reset mid-RUN aborts immediately; memory contents are not cleared.
- Memory: 1 write port, 1 synchronous read port. Writes take effect on the next edge when i_load_en=1 and state is IDLE or DONE; otherwise they are ignored.
- States:
  - IDLE: on i_start, latch len/loop, clear o_sent_cnt. If len==0 go to DONE, else issue read of address 0 and go to PRIME.
  - PRIME: 1 cycle. Head register is loaded with mem[0]; head_valid=1; go to RUN.
  - RUN: deliver = i_read & head_valid. o_trace_data = deliver ? head : 0 (combinational).
    - On deliver edge: o_sent_cnt+1 (saturate at all-ones).
    - If rd_ptr == len-1: with loop=0 go to DONE and clear head_valid; with loop=1 set next ptr=0.
    - Otherwise next ptr = rd_ptr+1.
    - The read address each cycle is next ptr when delivering, else rd_ptr. Head is therefore refreshed every edge, giving back-to-back delivery with zero bubbles.
  - DONE: output 0. i_start restarts exactly as from IDLE (reloaded memory allowed).
- i_stop in PRIME or RUN forces DONE at the next edge. Any entry delivered combinationally in that same cycle still counts. i_stop has priority over wrap/advance. i_start is ignored in PRIME/RUN.
- i_start and i_load_en in the same IDLE cycle: the write completes; the read of address 0 sees the old data if load_addr==0. Software must load before start.
- Write to the address being read in DONE: no hazard (no reads are consumed in DONE).
- No constraint on i_read pattern. The feeder never holds data across a non-read cycle visibly; output stays 0.

Test Plan:
- Load 3 entries {1,p=5,t=2,d=0xAAAA}, {0,idle=4}, {1,p=1,t=0,d=0x1}, len=3, loop=0, i_read held 1 → entries appear on three consecutive cycles after PRIME; then o_done=1, o_sent_cnt=3, output 0.
- Same trace, i_read pattern 1,0,0,1,0,1 → entries appear only in the read cycles in order; output 0 in the others; no entry skipped or repeated.
- len=2, loop=1, i_read=1 for 7 cycles in RUN → sequence e0,e1,e0,e1,e0,e1,e0; o_sent_cnt=7; o_busy stays 1.
- i_stop during RUN with i_read=1 → that cycle's entry delivered and counted; next cycle o_done=1, output 0; a following i_start replays from e0.
- Start with len=0 → DONE next cycle, o_sent_cnt=0, output never nonzero.
- Assert i_arst mid-RUN → outputs 0 immediately, state IDLE. i_load_en during RUN → memory unchanged, verified by replay.

Source files
------------

// File: rtl/trace_feeder.sv
// trace_feeder
//   Streams a trace that has been preloaded into an internal memory. Each
//   entry is {flag, payload}. The payload is either {priority, tree_id, data}
//   or an idle cycle count. An entry is presented only while the consumer
//   strobes i_read. At all other times o_trace_data is forced to zero.
//   Replay can be single-pass or looped, and a run can be aborted.
//
// Ports
//   i_clk, i_arst          clock, asynchronous active-high reset
//   i_load_en/addr/data    trace memory write port (accepted in IDLE/DONE only)
//   i_trace_len, i_loop    replay length and wrap mode, sampled on i_start
//   i_start, i_stop        start / abort pulses
//   i_read                 consumer read strobe
//   o_trace_data           delivered entry, '0 when not delivering
//   o_busy, o_done         PRIME/RUN and DONE state flags
//   o_sent_cnt             entries delivered since last start (saturating)
module trace_feeder #(
    parameter int TRACE_DATA_BITS = 25,
    parameter int DEPTH           = 1024,
    parameter int ADDR_BITS       = $clog2(DEPTH),
    parameter int LEN_BITS        = $clog2(DEPTH) + 1,
    parameter int CNT_BITS        = 32
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic                       i_load_en,
    input  logic [ADDR_BITS-1:0]       i_load_addr,
    input  logic [TRACE_DATA_BITS-1:0] i_load_data,
    input  logic [LEN_BITS-1:0]        i_trace_len,
    input  logic                       i_loop,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic                       i_read,
    output logic [TRACE_DATA_BITS-1:0] o_trace_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [CNT_BITS-1:0]        o_sent_cnt
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t                     state, state_nxt;
    logic [TRACE_DATA_BITS-1:0] mem [DEPTH];
    logic [TRACE_DATA_BITS-1:0] head;
    logic                       head_valid;
    logic [ADDR_BITS-1:0]       rd_ptr, ptr_nxt, rd_addr;
    logic [LEN_BITS-1:0]        len_q;
    logic                       loop_q;
    logic                       deliver;
    logic                       last;
    logic                       start_go;
    logic                       can_load;

    assign can_load = i_load_en && (state == IDLE || state == DONE);
    assign start_go = i_start && (state == IDLE || state == DONE);
    assign last     = ({1'b0, rd_ptr} == len_q - LEN_BITS'(1));

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        deliver      = 1'b0;
        ptr_nxt      = rd_ptr;
        rd_addr      = rd_ptr;
        o_trace_data = '0;
        o_busy       = (state == PRIME) || (state == RUN);
        o_done       = (state == DONE);
        case (state)
            IDLE, DONE: begin
                rd_addr = '0;
                if (i_start)
                    state_nxt = (i_trace_len == '0) ? DONE : PRIME;
            end
            PRIME: begin
                state_nxt = i_stop ? DONE : RUN;
            end
            RUN: begin
                deliver = i_read && head_valid;
                if (deliver) begin
                    if (last) begin
                        ptr_nxt = '0;
                        if (!loop_q) state_nxt = DONE;
                    end else begin
                        ptr_nxt = rd_ptr + ADDR_BITS'(1);
                    end
                end
                // Prefetch the entry that will be the head next cycle so
                // consecutive reads see no bubble.
                rd_addr = ptr_nxt;
                if (i_stop) state_nxt = DONE;
                if (deliver) o_trace_data = head;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Plain memory with one write and one registered read. It is left
    // unreset so that it maps onto block RAM. The head register is the RAM
    // output register. It is qualified by head_valid, so it never needs a
    // reset value.
    always_ff @(posedge i_clk) begin
        if (can_load) mem[i_load_addr] <= i_load_data;
        head <= mem[rd_addr];
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rd_ptr     <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            head_valid <= 1'b0;
            o_sent_cnt <= '0;
        end else begin
            // The head becomes meaningful only once the prime read has
            // landed. It drops as soon as the run leaves RUN.
            head_valid <= (state_nxt == RUN);
            if (start_go) begin
                len_q      <= i_trace_len;
                loop_q     <= i_loop;
                rd_ptr     <= '0;
                o_sent_cnt <= '0;
            end else if (deliver) begin
                rd_ptr <= ptr_nxt;
                if (o_sent_cnt != '1) o_sent_cnt <= o_sent_cnt + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_trace_feeder.sv
// Directed bench for trace_feeder. A table of per-cycle records gives the
// inputs to apply and the outputs expected before the next clock edge.
// Hand-written sequences cover asynchronous reset mid-run and writes that
// are attempted during RUN.
module tb_trace_feeder;
    localparam int W   = 25;
    localparam int AB  = 10;
    localparam int LB  = 11;
    localparam int CB  = 32;

    localparam logic [W-1:0] E0 = {1'b1, 4'd5, 4'd2, 16'hAAAA};
    localparam logic [W-1:0] E1 = {1'b0, 24'd4};
    localparam logic [W-1:0] E2 = {1'b1, 4'd1, 4'd0, 16'h0001};

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_load_en;
    logic [AB-1:0] i_load_addr;
    logic [W-1:0]  i_load_data;
    logic [LB-1:0] i_trace_len;
    logic          i_loop, i_start, i_stop, i_read;
    logic [W-1:0]  o_trace_data;
    logic          o_busy, o_done;
    logic [CB-1:0] o_sent_cnt;

    int n_cmp = 0;
    int n_err = 0;

    trace_feeder dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_load_en(i_load_en), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
        .i_trace_len(i_trace_len), .i_loop(i_loop),
        .i_start(i_start), .i_stop(i_stop), .i_read(i_read),
        .o_trace_data(o_trace_data), .o_busy(o_busy), .o_done(o_done),
        .o_sent_cnt(o_sent_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          start, stop, rd;
        logic [LB-1:0] len;
        logic          loop;
        logic [W-1:0]  data;
        logic          busy, done;
        logic [CB-1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic start, logic stop, logic rd, logic [LB-1:0] len,
                                logic loop, logic [W-1:0] data, logic busy, logic done,
                                logic [CB-1:0] cnt);
        vec_t v;
        v.start = start; v.stop = stop; v.rd = rd; v.len = len; v.loop = loop;
        v.data = data; v.busy = busy; v.done = done; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] d, input logic b,
                           input logic dn, input logic [CB-1:0] c);
        chk({tag, ".data"}, 32'(o_trace_data), 32'(d));
        chk({tag, ".busy"}, 32'(o_busy), 32'(b));
        chk({tag, ".done"}, 32'(o_done), 32'(dn));
        chk({tag, ".cnt"},  o_sent_cnt, c);
    endtask

    task automatic load(input logic [AB-1:0] a, input logic [W-1:0] d);
        @(negedge i_clk);
        i_load_en = 1'b1; i_load_addr = a; i_load_data = d;
        @(negedge i_clk);
        i_load_en = 1'b0;
    endtask

    // Drives one cycle of inputs at the falling edge, checks before the rising edge.
    task automatic cyc(input logic start, input logic stop, input logic rd,
                       input logic [LB-1:0] len, input logic loop);
        @(negedge i_clk);
        i_start = start; i_stop = stop; i_read = rd; i_trace_len = len; i_loop = loop;
        #2;
    endtask

    initial begin
        i_arst = 1'b1; i_load_en = 1'b0; i_load_addr = '0; i_load_data = '0;
        i_trace_len = '0; i_loop = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_read = 1'b0;
        #1;
        chk_all("reset", '0, 1'b0, 1'b0, '0);
        #11 i_arst = 1'b0;

        load(10'd0, E0);
        load(10'd1, E1);
        load(10'd2, E2);

        // single pass, read held high
        vecs.push_back(mk(1,0,1,3,0, '0,0,0,0));
        vecs.push_back(mk(0,0,1,3,0, '0,1,0,0));
        vecs.push_back(mk(0,0,1,3,0, E0,1,0,0));
        vecs.push_back(mk(0,0,1,3,0, E1,1,0,1));
        vecs.push_back(mk(0,0,1,3,0, E2,1,0,2));
        vecs.push_back(mk(0,0,1,3,0, '0,0,1,3));
        // sparse reads 1,0,0,1,0,1
        vecs.push_back(mk(1,0,0,3,0, '0,0,1,3));
        vecs.push_back(mk(0,0,0,3,0, '0,1,0,0));
        vecs.push_back(mk(0,0,1,3,0, E0,1,0,0));
        vecs.push_back(mk(0,0,0,3,0, '0,1,0,1));
        vecs.push_back(mk(0,0,0,3,0, '0,1,0,1));
        vecs.push_back(mk(0,0,1,3,0, E1,1,0,1));
        vecs.push_back(mk(0,0,0,3,0, '0,1,0,2));
        vecs.push_back(mk(0,0,1,3,0, E2,1,0,2));
        vecs.push_back(mk(0,0,0,3,0, '0,0,1,3));
        // looped len=2, seven reads; the start in RUN is ignored; stop without delivery
        vecs.push_back(mk(1,0,0,2,1, '0,0,1,3));
        vecs.push_back(mk(0,0,0,2,1, '0,1,0,0));
        vecs.push_back(mk(0,0,1,2,1, E0,1,0,0));
        vecs.push_back(mk(0,0,1,2,1, E1,1,0,1));
        vecs.push_back(mk(0,0,1,2,1, E0,1,0,2));
        vecs.push_back(mk(1,0,1,0,0, E1,1,0,3));
        vecs.push_back(mk(0,0,1,2,1, E0,1,0,4));
        vecs.push_back(mk(0,0,1,2,1, E1,1,0,5));
        vecs.push_back(mk(0,0,1,2,1, E0,1,0,6));
        vecs.push_back(mk(0,1,0,2,1, '0,1,0,7));
        vecs.push_back(mk(0,0,1,2,1, '0,0,1,7));
        // stop while delivering: the entry counts, then replay from e0
        vecs.push_back(mk(1,0,0,3,0, '0,0,1,7));
        vecs.push_back(mk(0,0,0,3,0, '0,1,0,0));
        vecs.push_back(mk(0,0,1,3,0, E0,1,0,0));
        vecs.push_back(mk(0,1,1,3,0, E1,1,0,1));
        vecs.push_back(mk(0,0,1,3,0, '0,0,1,2));
        vecs.push_back(mk(1,0,1,3,0, '0,0,1,2));
        vecs.push_back(mk(0,0,1,3,0, '0,1,0,0));
        vecs.push_back(mk(0,0,1,3,0, E0,1,0,0));
        vecs.push_back(mk(0,1,0,3,0, '0,1,0,1));
        vecs.push_back(mk(0,0,0,3,0, '0,0,1,1));
        // zero-length start
        vecs.push_back(mk(1,0,1,0,0, '0,0,1,1));
        vecs.push_back(mk(0,0,1,0,0, '0,0,1,0));
        vecs.push_back(mk(0,0,1,0,0, '0,0,1,0));
        // stop in PRIME
        vecs.push_back(mk(1,0,0,3,0, '0,0,1,0));
        vecs.push_back(mk(0,1,1,3,0, '0,1,0,0));
        vecs.push_back(mk(0,0,1,3,0, '0,0,1,0));

        foreach (vecs[k]) begin
            cyc(vecs[k].start, vecs[k].stop, vecs[k].rd, vecs[k].len, vecs[k].loop);
            chk_all($sformatf("vec%0d", k), vecs[k].data, vecs[k].busy, vecs[k].done, vecs[k].cnt);
        end

        // Looped run with a write to entry 0 attempted during RUN, then async reset.
        cyc(1,0,0,3,1);
        cyc(0,0,0,3,1);
        @(negedge i_clk);
        i_start = 1'b0; i_read = 1'b1;
        i_load_en = 1'b1; i_load_addr = 10'd0; i_load_data = 25'h0123456;
        #2 chk("run_load.e0", 32'(o_trace_data), 32'(E0));
        @(negedge i_clk);
        i_load_en = 1'b0;
        #2 chk("run_load.e1", 32'(o_trace_data), 32'(E1));
        i_arst = 1'b1;
        #1 chk_all("arst_mid_run", '0, 1'b0, 1'b0, '0);
        @(negedge i_clk);
        #2 chk_all("arst_held", '0, 1'b0, 1'b0, '0);
        i_arst = 1'b0;

        // Replay shows entry 0 was not overwritten and ptr restarted at 0.
        cyc(1,0,1,3,0);
        chk_all("post_rst_idle", '0, 1'b0, 1'b0, '0);
        cyc(0,0,1,3,0);
        cyc(0,0,1,3,0);
        chk_all("replay.e0", E0, 1'b1, 1'b0, 32'd0);
        cyc(0,0,1,3,0);
        chk_all("replay.e1", E1, 1'b1, 1'b0, 32'd1);
        cyc(0,0,1,3,0);
        chk_all("replay.e2", E2, 1'b1, 1'b0, 32'd2);
        cyc(0,0,0,3,0);
        chk_all("replay.done", '0, 1'b0, 1'b1, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
